// File: rtl/i4004_pc_stack.sv
// Program counter with a circular return-address stack and nibble-serial address output.
// Stack pointer wraps by explicit compare so any LEVELS >= 1 works.
module i4004_pc_stack #(
    parameter int unsigned NIBBLES = 3,
    parameter int unsigned LEVELS  = 3,
    localparam int unsigned ADDR_W  = 4 * NIBBLES,
    localparam int unsigned SEL_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1,
    localparam int unsigned DEPTH_W = $clog2(LEVELS + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_op_valid,
    input  logic [2:0]         i_op,
    input  logic [ADDR_W-1:0]  i_load_addr,
    input  logic               i_nib_req,
    input  logic [SEL_W-1:0]   i_nib_sel,
    input  logic               i_err_clr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [3:0]         o_nib_out,
    output logic [DEPTH_W-1:0] o_depth,
    output logic               o_ovf,
    output logic               o_unf
);
    localparam int unsigned SP_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam logic [2:0] OP_INC   = 3'd1;
    localparam logic [2:0] OP_JUMP  = 3'd2;
    localparam logic [2:0] OP_JPAGE = 3'd3;
    localparam logic [2:0] OP_CALL  = 3'd4;
    localparam logic [2:0] OP_RET   = 3'd5;
    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(8'hFF);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_stack [LEVELS];
    logic [SP_W-1:0]    r_sp;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_ovf;
    logic               r_unf;
    logic [3:0]         r_nib;

    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [SP_W-1:0]    w_sp_nxt;
    logic [SP_W-1:0]    w_sp_inc;
    logic [SP_W-1:0]    w_sp_dec;
    logic [DEPTH_W-1:0] w_depth_nxt;
    logic               w_push;
    logic               w_set_ovf;
    logic               w_set_unf;
    logic [ADDR_W-1:0]  w_nib_sh;
    logic [3:0]         w_nib;

    assign w_sp_inc = (r_sp == SP_W'(LEVELS - 1)) ? '0 : r_sp + SP_W'(1);
    assign w_sp_dec = (r_sp == '0) ? SP_W'(LEVELS - 1) : r_sp - SP_W'(1);

    // Op decode: next pc, stack pointer, depth and error events
    always_comb begin
        w_pc_nxt    = r_pc;
        w_sp_nxt    = r_sp;
        w_depth_nxt = r_depth;
        w_push      = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        if (i_op_valid) begin
            case (i_op)
                OP_INC:   w_pc_nxt = r_pc + ADDR_W'(1);
                OP_JUMP:  w_pc_nxt = i_load_addr;
                OP_JPAGE: w_pc_nxt = (r_pc & ~PAGE_MASK) | (i_load_addr & PAGE_MASK);
                OP_CALL: begin
                    w_push   = 1'b1;
                    w_sp_nxt = w_sp_inc;
                    w_pc_nxt = i_load_addr;
                    if (r_depth < DEPTH_W'(LEVELS)) w_depth_nxt = r_depth + DEPTH_W'(1);
                    else                            w_set_ovf   = 1'b1;
                end
                OP_RET: begin
                    w_sp_nxt = w_sp_dec;
                    w_pc_nxt = r_stack[w_sp_dec];
                    if (r_depth != '0) w_depth_nxt = r_depth - DEPTH_W'(1);
                    else               w_set_unf   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Nibble select from the pre-op pc; out-of-range index yields zero
    assign w_nib_sh = r_pc >> {i_nib_sel, 2'b00};
    always_comb begin
        w_nib = w_nib_sh[3:0];
        if (32'(i_nib_sel) >= NIBBLES) w_nib = 4'h0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc    <= '0;
            r_stack <= '{default: '0};
            r_sp    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_nib   <= 4'h0;
        end else if (i_en) begin
            r_pc    <= w_pc_nxt;
            r_sp    <= w_sp_nxt;
            r_depth <= w_depth_nxt;
            if (w_push) r_stack[r_sp] <= r_pc;
            r_ovf   <= (r_ovf & ~i_err_clr) | w_set_ovf;
            r_unf   <= (r_unf & ~i_err_clr) | w_set_unf;
            if (i_nib_req) r_nib <= w_nib;
        end
    end

    assign o_pc      = r_pc;
    assign o_nib_out = r_nib;
    assign o_depth   = r_depth;
    assign o_ovf     = r_ovf;
    assign o_unf     = r_unf;

endmodule

// File: tb/tb_i4004_pc_stack.sv
// Directed bench for i4004_pc_stack: default 3-nibble/3-level instance
// plus a 4-nibble/5-level instance sharing the same stimulus.
module tb_i4004_pc_stack;
    localparam logic [2:0] NOP = 3'd0, INC = 3'd1, JMP = 3'd2, JPG = 3'd3, CALL = 3'd4, RET = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = NOP;
    logic [15:0] load_addr = '0;
    logic        nib_req = 1'b0;
    logic [1:0]  nib_sel = '0;
    logic        err_clr = 1'b0;

    logic [11:0] pc_a;
    logic [3:0]  nib_a;
    logic [1:0]  depth_a;
    logic        ovf_a, unf_a;
    logic [15:0] pc_b;
    logic [3:0]  nib_b;
    logic [2:0]  depth_b;
    logic        ovf_b, unf_b;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i4004_pc_stack #(.NIBBLES(3), .LEVELS(3)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_op_valid(op_valid), .i_op(op),
        .i_load_addr(load_addr[11:0]), .i_nib_req(nib_req), .i_nib_sel(nib_sel),
        .i_err_clr(err_clr), .o_pc(pc_a), .o_nib_out(nib_a), .o_depth(depth_a),
        .o_ovf(ovf_a), .o_unf(unf_a)
    );

    i4004_pc_stack #(.NIBBLES(4), .LEVELS(5)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_op_valid(op_valid), .i_op(op),
        .i_load_addr(load_addr), .i_nib_req(nib_req), .i_nib_sel(nib_sel),
        .i_err_clr(err_clr), .o_pc(pc_b), .o_nib_out(nib_b), .o_depth(depth_b),
        .o_ovf(ovf_b), .o_unf(unf_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One enabled edge with the given stimulus; inputs return to idle afterwards
    task automatic cyc(input logic v, input logic [2:0] o, input logic [15:0] a,
                       input logic nr, input logic [1:0] ns, input logic ec);
        op_valid = v; op = o; load_addr = a; nib_req = nr; nib_sel = ns; err_clr = ec;
        @(posedge clk); #1;
        op_valid = 1'b0; op = NOP; nib_req = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [15:0] a);
        cyc(1'b1, o, a, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_pc", 32'(pc_a), 32'h0);
        chk("rst_depth", 32'(depth_a), 32'h0);
        chk("rst_flags", {30'd0, ovf_a, unf_a}, 32'h0);
        chk("rst_nib", 32'(nib_a), 32'h0);

        // INC wraps
        do_op(JMP, 16'h0FFF);
        do_op(INC, 16'h0);
        chk("inc_wrap_pc", 32'(pc_a), 32'h000);
        chk("inc_wrap_flags", {30'd0, ovf_a, unf_a}, 32'h0);

        // Nesting
        do_op(JMP, 16'h0100);
        do_op(CALL, 16'h0200);
        do_op(CALL, 16'h0300);
        do_op(CALL, 16'h0400);
        chk("nest_depth", 32'(depth_a), 32'd3);
        chk("nest_pc", 32'(pc_a), 32'h400);
        do_op(RET, 16'h0);
        chk("nest_ret1", 32'(pc_a), 32'h300);
        do_op(RET, 16'h0);
        chk("nest_ret2", 32'(pc_a), 32'h200);
        do_op(RET, 16'h0);
        chk("nest_ret3", 32'(pc_a), 32'h100);
        chk("nest_depth0", 32'(depth_a), 32'd0);
        chk("nest_flags", {30'd0, ovf_a, unf_a}, 32'h0);

        // Overflow / underflow
        do_reset();
        do_op(JMP, 16'h0010);
        do_op(CALL, 16'h0020);
        do_op(CALL, 16'h0030);
        do_op(CALL, 16'h0040);
        chk("ovf_not_yet", 32'(ovf_a), 32'd0);
        do_op(CALL, 16'h0050);
        chk("ovf_set", 32'(ovf_a), 32'd1);
        chk("ovf_depth", 32'(depth_a), 32'd3);
        do_op(RET, 16'h0);
        chk("ovf_ret1", 32'(pc_a), 32'h040);
        do_op(RET, 16'h0);
        chk("ovf_ret2", 32'(pc_a), 32'h030);
        do_op(RET, 16'h0);
        chk("ovf_ret3", 32'(pc_a), 32'h020);
        chk("ovf_unf_clear", 32'(unf_a), 32'd0);
        do_op(RET, 16'h0);
        chk("unf_pc_stale", 32'(pc_a), 32'h040);
        chk("unf_set", 32'(unf_a), 32'd1);
        chk("unf_depth", 32'(depth_a), 32'd0);
        cyc(1'b0, NOP, 16'h0, 1'b0, 2'd0, 1'b1);
        chk("errclr_flags", {30'd0, ovf_a, unf_a}, 32'h0);
        cyc(1'b1, RET, 16'h0, 1'b0, 2'd0, 1'b1);
        chk("errclr_set_wins", 32'(unf_a), 32'd1);
        chk("errclr_ret5_pc", 32'(pc_a), 32'h030);

        // JUMP_PAGE after INC crosses page
        do_op(JMP, 16'h03FE);
        do_op(INC, 16'h0);
        do_op(JPG, 16'h0A55);
        chk("jpage_1", 32'(pc_a), 32'h355);
        do_op(JMP, 16'h03FF);
        do_op(INC, 16'h0);
        do_op(JPG, 16'h0012);
        chk("jpage_2", 32'(pc_a), 32'h412);

        // Nibble emission with concurrent INC
        do_op(JMP, 16'h0ABC);
        cyc(1'b0, NOP, 16'h0, 1'b1, 2'd0, 1'b0);
        chk("nib0", 32'(nib_a), 32'hC);
        cyc(1'b0, NOP, 16'h0, 1'b1, 2'd1, 1'b0);
        chk("nib1", 32'(nib_a), 32'hB);
        cyc(1'b1, INC, 16'h0, 1'b1, 2'd2, 1'b0);
        chk("nib2", 32'(nib_a), 32'hA);
        chk("nib2_pc", 32'(pc_a), 32'hABD);
        cyc(1'b0, NOP, 16'h0, 1'b0, 2'd0, 1'b0);
        chk("nib_hold", 32'(nib_a), 32'hA);
        cyc(1'b0, NOP, 16'h0, 1'b1, 2'd3, 1'b0);
        chk("nib3_zero", 32'(nib_a), 32'h0);

        // Disabled edges freeze everything (unf still set from above)
        en = 1'b0;
        cyc(1'b1, CALL, 16'h0777, 1'b1, 2'd0, 1'b1);
        cyc(1'b1, INC, 16'h0, 1'b1, 2'd1, 1'b1);
        cyc(1'b1, RET, 16'h0, 1'b0, 2'd0, 1'b0);
        chk("en0_pc", 32'(pc_a), 32'hABD);
        chk("en0_depth", 32'(depth_a), 32'd0);
        chk("en0_nib", 32'(nib_a), 32'h0);
        chk("en0_unf", 32'(unf_a), 32'd1);
        en = 1'b1;

        // Async reset between edges while CALL is pending
        op_valid = 1'b1; op = CALL; load_addr = 16'h0123;
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", 32'(pc_a), 32'h0);
        chk("arst_unf", 32'(unf_a), 32'd0);
        chk("arst_depth", 32'(depth_a), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0; op = NOP;
        chk("arst_first_pc", 32'(pc_a), 32'h123);
        chk("arst_first_depth", 32'(depth_a), 32'd1);

        // Wide instance: wrap, nibble 3, nesting and overflow with LEVELS=5
        do_reset();
        chk("b_rst_pc", 32'(pc_b), 32'h0);
        do_op(JMP, 16'hFFFF);
        do_op(INC, 16'h0);
        chk("b_inc_wrap", 32'(pc_b), 32'h0000);
        do_op(JMP, 16'hABCD);
        cyc(1'b0, NOP, 16'h0, 1'b1, 2'd3, 1'b0);
        chk("b_nib3", 32'(nib_b), 32'hA);
        do_op(JMP, 16'h1000);
        for (int i = 2; i <= 6; i++) do_op(CALL, 16'(i * 16'h1000));
        chk("b_nest_depth", 32'(depth_b), 32'd5);
        chk("b_nest_ovf", 32'(ovf_b), 32'd0);
        for (int i = 5; i >= 1; i--) begin
            do_op(RET, 16'h0);
            chk("b_nest_ret", 32'(pc_b), 32'(i * 32'h1000));
        end
        chk("b_nest_flags", {30'd0, ovf_b, unf_b}, 32'h0);

        do_reset();
        do_op(JMP, 16'h0010);
        for (int i = 2; i <= 6; i++) do_op(CALL, 16'(i * 16'h10));
        chk("b_ovf_not_yet", 32'(ovf_b), 32'd0);
        do_op(CALL, 16'h0070);
        chk("b_ovf_set", 32'(ovf_b), 32'd1);
        chk("b_ovf_depth", 32'(depth_b), 32'd5);
        for (int i = 6; i >= 2; i--) begin
            do_op(RET, 16'h0);
            chk("b_ovf_ret", 32'(pc_b), 32'(i * 32'h10));
        end
        chk("b_unf_not_yet", 32'(unf_b), 32'd0);
        do_op(RET, 16'h0);
        chk("b_unf_pc_stale", 32'(pc_b), 32'h060);
        chk("b_unf_set", 32'(unf_b), 32'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
